// File: rtl/vga_pkg.sv
// Shared constants and helpers for the dithered VGA output path.
package vga_pkg;

    localparam int unsigned BAYER_W = 4;

    // uo_pack bit positions for the TinyVGA pin order
    localparam int unsigned UO_R1 = 0;
    localparam int unsigned UO_G1 = 1;
    localparam int unsigned UO_B1 = 2;
    localparam int unsigned UO_VS = 3;
    localparam int unsigned UO_R0 = 4;
    localparam int unsigned UO_G0 = 5;
    localparam int unsigned UO_B0 = 6;
    localparam int unsigned UO_HS = 7;

    localparam logic SYNC_IDLE = 1'b1;

    localparam logic [BAYER_W-1:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    typedef struct packed {
        logic [1:0] b;
        logic [1:0] g;
        logic [1:0] r;
    } rgb2_t;

    // Round the 2-bit level up when the fraction beats the threshold; saturates at 3
    function automatic logic [1:0] quantise(input logic [1:0] q,
                                            input logic [BAYER_W-1:0] f,
                                            input logic [BAYER_W-1:0] t);
        return ((f > t) && (q != 2'd3)) ? q + 2'd1 : q;
    endfunction

endpackage

// File: rtl/bayer4_threshold.sv
// 4x4 ordered-dither threshold ROM.
module bayer4_threshold
    import vga_pkg::*;
(
    input  logic [1:0]         xi,
    input  logic [1:0]         yi,
    output logic [BAYER_W-1:0] t_c
);

    assign t_c = BAYER4[yi][xi];

endmodule

// File: rtl/vga_dither_output.sv
// Two-stage output stage: Bayer-dithers colour to 2 bits/channel, blanks, aligns syncs.
module vga_dither_output
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W     = 6,
    parameter bit          TEMPORAL_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               h_sync,
    input  logic               v_sync,
    input  logic               frame_active,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [1:0]         r,
    output logic [1:0]         g,
    output logic [1:0]         b,
    output logic               h_sync_o,
    output logic               v_sync_o,
    output logic [7:0]         uo_pack,
    output logic [7:0]         frame_cnt
);

    localparam int unsigned F = COLOR_W - 2;

    logic                  vs_prev;
    logic [1:0]            xi_c;
    logic [BAYER_W-1:0]    t_c;
    logic [2:0][COLOR_W-1:0] c1;
    logic                  hs1;
    logic                  vs1;
    logic                  act1;
    logic [BAYER_W-1:0]    t1;
    logic [2:0][1:0]       q_c;
    rgb2_t                 px_c;
    logic [7:0]            pack_c;
    logic                  xy_unused;

    assign xy_unused = ^{x[9:2], y[9:2]};

    assign xi_c = TEMPORAL_EN ? (x[1:0] + frame_cnt[1:0]) : x[1:0];

    bayer4_threshold u_bayer (
        .xi  (xi_c),
        .yi  (y[1:0]),
        .t_c (t_c)
    );

    // Frame counter on falling edges of the raw v_sync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev   <= SYNC_IDLE;
            frame_cnt <= 8'd0;
        end else begin
            vs_prev <= v_sync;
            if (vs_prev && !v_sync) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Stage 1: capture pixel, syncs and its threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1   <= '0;
            hs1  <= SYNC_IDLE;
            vs1  <= SYNC_IDLE;
            act1 <= 1'b0;
            t1   <= '0;
        end else begin
            c1   <= {b_in, g_in, r_in};
            hs1  <= h_sync;
            vs1  <= v_sync;
            act1 <= frame_active;
            t1   <= t_c;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [1:0]         q;
        logic [BAYER_W-1:0] f4;
        assign q = c1[ch][COLOR_W-1 -: 2];
        if (F >= BAYER_W) begin : g_trunc
            assign f4 = c1[ch][F-1 -: BAYER_W];
        end else begin : g_pad
            assign f4 = {c1[ch][F-1:0], {(BAYER_W-F){1'b0}}};
        end
        assign q_c[ch] = quantise(q, f4, t1);
    end

    assign px_c = act1 ? rgb2_t'{r: q_c[0], g: q_c[1], b: q_c[2]} : '0;

    always_comb begin
        pack_c        = '0;
        pack_c[UO_HS] = hs1;
        pack_c[UO_B0] = px_c.b[0];
        pack_c[UO_G0] = px_c.g[0];
        pack_c[UO_R0] = px_c.r[0];
        pack_c[UO_VS] = vs1;
        pack_c[UO_B1] = px_c.b[1];
        pack_c[UO_G1] = px_c.g[1];
        pack_c[UO_R1] = px_c.r[1];
    end

    // Stage 2: registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r        <= 2'd0;
            g        <= 2'd0;
            b        <= 2'd0;
            h_sync_o <= SYNC_IDLE;
            v_sync_o <= SYNC_IDLE;
            uo_pack  <= 8'h88;
        end else begin
            r        <= px_c.r;
            g        <= px_c.g;
            b        <= px_c.b;
            h_sync_o <= hs1;
            v_sync_o <= vs1;
            uo_pack  <= pack_c;
        end
    end

endmodule

// File: tb/tb_vga_dither_output.sv
// Bench for vga_dither_output: static and temporal instances against a pixel-level model.
module tb_vga_dither_output;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       h_sync = 1'b1;
    logic       v_sync = 1'b1;
    logic       frame_active = 1'b0;
    logic [5:0] r_in = '0;
    logic [5:0] g_in = '0;
    logic [5:0] b_in = '0;

    logic [1:0] s_r, s_g, s_b, t_r, t_g, t_b;
    logic       s_hs, s_vs, t_hs, t_vs;
    logic [7:0] s_pack, t_pack, s_fc, t_fc;

    always #5 clk = ~clk;

    vga_dither_output #(.COLOR_W(6), .TEMPORAL_EN(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .h_sync(h_sync), .v_sync(v_sync),
        .frame_active(frame_active), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .r(s_r), .g(s_g), .b(s_b), .h_sync_o(s_hs), .v_sync_o(s_vs),
        .uo_pack(s_pack), .frame_cnt(s_fc)
    );

    vga_dither_output #(.COLOR_W(6), .TEMPORAL_EN(1'b1)) dut_t (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .h_sync(h_sync), .v_sync(v_sync),
        .frame_active(frame_active), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .r(t_r), .g(t_g), .b(t_b), .h_sync_o(t_hs), .v_sync_o(t_vs),
        .uo_pack(t_pack), .frame_cnt(t_fc)
    );

    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    int checks = 0;
    int failures = 0;
    int mfc = 0;
    bit mvs_prev = 1'b1;
    int p_s [3];
    int p_t [3];
    bit p_hs;
    bit p_vs;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected 2-bit level for a 6-bit channel: level = c/16, bumped when c%16 exceeds the threshold
    function automatic int model(int c, int xx, int yy, bit act, int fc, bit temporal);
        int q, f, xi, t;
        if (!act) return 0;
        q  = c / 16;
        f  = c % 16;
        xi = temporal ? (xx + fc) % 4 : xx % 4;
        t  = bayer[yy % 4][xi];
        return (f > t && q < 3) ? q + 1 : q;
    endfunction

    function automatic int pack(int hs, int vs, int rr, int gg, int bb);
        return hs * 128 + (bb % 2) * 64 + (gg % 2) * 32 + (rr % 2) * 16 +
               vs * 8 + (bb / 2) * 4 + (gg / 2) * 2 + (rr / 2);
    endfunction

    task automatic reset_model();
        p_s      = '{0, 0, 0};
        p_t      = '{0, 0, 0};
        p_hs     = 1'b1;
        p_vs     = 1'b1;
        mfc      = 0;
        mvs_prev = 1'b1;
    endtask

    task automatic set_px(input int xx, input int yy, input int cr, input int cg, input int cb,
                          input bit act, input bit hs, input bit vs);
        x            = 10'(xx);
        y            = 10'(yy);
        r_in         = 6'(cr);
        g_in         = 6'(cg);
        b_in         = 6'(cb);
        frame_active = act;
        h_sync       = hs;
        v_sync       = vs;
    endtask

    // One pixel clock: predict current inputs, then check outputs of the pixel one step older
    task automatic step();
        int cin [3];
        int cs [3];
        int ct [3];
        cin = '{int'(r_in), int'(g_in), int'(b_in)};
        for (int ch = 0; ch < 3; ch++) begin
            cs[ch] = model(cin[ch], int'(x), int'(y), frame_active, mfc, 1'b0);
            ct[ch] = model(cin[ch], int'(x), int'(y), frame_active, mfc, 1'b1);
        end
        if (mvs_prev && !v_sync) mfc = (mfc + 1) % 256;
        mvs_prev = v_sync;
        @(posedge clk);
        #1;
        chk("r_static", int'(s_r), p_s[0]);
        chk("g_static", int'(s_g), p_s[1]);
        chk("b_static", int'(s_b), p_s[2]);
        chk("r_temporal", int'(t_r), p_t[0]);
        chk("g_temporal", int'(t_g), p_t[1]);
        chk("b_temporal", int'(t_b), p_t[2]);
        chk("h_sync_o", int'(s_hs), int'(p_hs));
        chk("v_sync_o", int'(t_vs), int'(p_vs));
        chk("uo_pack_static", int'(s_pack), pack(p_hs, p_vs, p_s[0], p_s[1], p_s[2]));
        chk("uo_pack_temporal", int'(t_pack), pack(p_hs, p_vs, p_t[0], p_t[1], p_t[2]));
        chk("frame_cnt", int'(t_fc), mfc);
        chk("frame_cnt_static", int'(s_fc), mfc);
        p_s  = cs;
        p_t  = ct;
        p_hs = h_sync;
        p_vs = v_sync;
    endtask

    task automatic sweep(input int c);
        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                set_px(int'($urandom_range(0, 159)) * 4 + xx, int'($urandom_range(0, 119)) * 4 + yy,
                       c, c, c, 1'b1, 1'b1, 1'b1);
                step();
            end
        end
    endtask

    initial begin
        reset_model();
        set_px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 63, 63, 63, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_uo_pack", int'(s_pack), 8'h88);
        chk("reset_frame_cnt", int'(t_fc), 0);
        chk("reset_r", int'(t_r), 0);
        chk("reset_h_sync_o", int'(t_hs), 1);
        @(posedge clk);
        #1;
        set_px(5, 7, 63, 63, 63, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        step();
        step();

        sweep(63);
        sweep(0);
        sweep(16);
        sweep(24);

        // Density directed points on the static instance
        set_px(0, 0, 24, 24, 24, 1'b1, 1'b1, 1'b1);
        step();
        set_px(1, 0, 24, 24, 24, 1'b1, 1'b1, 1'b1);
        step();
        chk("density_x0y0", int'(s_r), 2);
        step();
        chk("density_x1y0", int'(s_r), 1);

        // Blanking
        set_px(2, 2, 63, 63, 63, 1'b0, 1'b1, 1'b1);
        step();
        step();
        chk("blank_r", int'(s_r), 0);

        // Single-cycle h_sync pulse
        set_px(8, 3, 40, 20, 10, 1'b1, 1'b0, 1'b1);
        step();
        chk("hs_pulse_n", int'(s_hs), 1);
        set_px(9, 3, 40, 20, 10, 1'b1, 1'b1, 1'b1);
        step();
        chk("hs_pulse_n2", int'(s_hs), 0);
        chk("hs_pulse_pack7", int'(s_pack[7]), 0);
        step();
        chk("hs_pulse_after", int'(s_hs), 1);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            set_px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                   ($urandom % 4) != 0, ($urandom % 8) != 0, ($urandom % 16) != 0);
            step();
        end

        // Asynchronous reset while busy
        set_px(1, 1, 63, 63, 63, 1'b1, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_uo_pack", int'(s_pack), 8'h88);
        chk("midrst_r", int'(t_r), 0);
        chk("midrst_frame_cnt", int'(t_fc), 0);
        chk("midrst_v_sync_o", int'(s_vs), 1);
        @(posedge clk);
        #1;
        reset_model();
        set_px(0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        step();

        // Frame counter: 3 edges, then wrap at 256, then one more
        for (int e = 0; e < 3; e++) begin
            v_sync = 1'b0;
            step();
            v_sync = 1'b1;
            step();
        end
        chk("frame_cnt_3", int'(t_fc), 3);
        for (int e = 3; e < 256; e++) begin
            v_sync = 1'b0;
            step();
            v_sync = 1'b1;
            step();
        end
        chk("frame_cnt_wrap", int'(t_fc), 0);
        v_sync = 1'b0;
        step();
        v_sync = 1'b1;
        step();
        chk("frame_cnt_1", int'(t_fc), 1);

        // Temporal rotation: frame 1, (3,0) maps to xi=0 -> T=0
        set_px(3, 0, 24, 24, 24, 1'b1, 1'b1, 1'b1);
        step();
        set_px(0, 1, 0, 0, 0, 1'b1, 1'b1, 1'b1);
        step();
        chk("temporal_x3y0", int'(t_r), 2);
        chk("static_x3y0", int'(s_r), 1);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
